// File: rtl/thumb_encoder.sv
// Thumb-subset instruction encoder: turns one decoded operation per handshake into
// 16-bit halfwords and packs them little-endian into sequential 32-bit memory writes.
module thumb_encoder #(
    parameter int          ADDR_W = 10,
    parameter int unsigned BASE   = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        op,
    input  logic [2:0]        rd,
    input  logic [2:0]        rn,
    input  logic [2:0]        rm,
    input  logic [3:0]        cond,
    input  logic [20:0]       imm,
    input  logic              flush,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              err,
    output logic              dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is low in BL2 and while reset is asserted.

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BL2  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_RESET = ADDR_W'(BASE);

    state_t              state_q, state_d;
    logic                pend_q, pend_d;
    logic [15:0]         low_q, low_d;
    logic [10:0]         bl_lo_q, bl_lo_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                err_q, err_d;

    logic                accept;
    logic                hw_valid;
    logic [15:0]         hw;

    assign req_ready = (state_q == S_IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign err       = err_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        low_d    = low_q;
        bl_lo_d  = bl_lo_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        err_d    = 1'b0;
        hw_valid = 1'b0;
        hw       = 16'h0000;
        // The address of a completed word is shown for one cycle, then advances.
        addr_d   = we_q ? addr_q + ADDR_ONE : addr_q;

        if (state_q == S_BL2) begin
            hw_valid = 1'b1;
            hw       = {5'b11111, bl_lo_q};
            state_d  = S_IDLE;
        end else if (accept) begin
            hw_valid = 1'b1;
            case (op)
                5'd0:  hw = {5'b00100, rd, imm[7:0]};
                5'd1:  hw = {5'b00110, rd, imm[7:0]};
                5'd2:  hw = {5'b00111, rd, imm[7:0]};
                5'd3:  hw = {7'b0001100, rm, rn, rd};
                5'd4:  hw = {7'b0001101, rm, rn, rd};
                5'd5:  hw = {5'b00000, imm[4:0], rm, rd};
                5'd6:  hw = {5'b00001, imm[4:0], rm, rd};
                5'd7:  hw = {5'b00010, imm[4:0], rm, rd};
                5'd8:  hw = {10'b0100000000, rm, rd};
                5'd9:  hw = {10'b0100000001, rm, rd};
                5'd10: hw = {10'b0100001100, rm, rd};
                5'd11: hw = {10'b0100001101, rn, rd};
                5'd12: hw = {10'b0100001111, rm, rd};
                5'd13: hw = {10'b0100001001, rn, rd};
                5'd14: hw = {5'b11100, imm[10:0]};
                5'd15: hw = {4'b1101, cond, imm[7:0]};
                5'd16: begin
                    hw      = {6'b111100, imm[20:11]};
                    bl_lo_d = imm[10:0];
                    state_d = S_BL2;
                end
                5'd17: hw = {8'b11011111, imm[7:0]};
                5'd18: hw = 16'hB500;
                5'd19: hw = 16'hBD00;
                default: begin
                    hw_valid = 1'b0;
                    err_d    = 1'b1;
                end
            endcase
        end

        if (hw_valid) begin
            if (pend_q) begin
                we_d    = 1'b1;
                wdata_d = {hw, low_q};
                pend_d  = 1'b0;
            end else begin
                low_d  = hw;
                pend_d = 1'b1;
            end
        end else if (flush && (state_q == S_IDLE) && !accept && pend_q) begin
            we_d    = 1'b1;
            wdata_d = {16'h0000, low_q};
            pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pend_q  <= 1'b0;
            low_q   <= 16'h0000;
            bl_lo_q <= 11'h000;
            addr_q  <= ADDR_RESET;
            we_q    <= 1'b0;
            wdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            low_q   <= low_d;
            bl_lo_q <= bl_lo_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

endmodule
